// File: rtl/writeback_stage.sv
// writeback_stage: commits retiring results to the register file or data memory, sequencing MUL/DIV as two register writes.
module writeback_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 5,
    parameter logic [3:0] OPC_MUL   = 4'b0101,
    parameter logic [3:0] OPC_DIV   = 4'b0110,
    parameter logic [3:0] OPC_STORE = 4'b1001,
    parameter logic [3:0] OPC_CMP   = 4'b1010,
    parameter logic [3:0] OPC_NOP   = 4'b1111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          opcode,
    input  logic [REG_AW-1:0]   rd,
    input  logic [MEM_AW-1:0]   mem_addr,
    input  logic [2*DATA_W-1:0] result,
    input  logic                zero_flag,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                flag_z,
    output logic [15:0]         retire_count
);
    localparam logic [2:0] IDLE = 3'd0, WR_LO = 3'd1, WR_HI = 3'd2, WR_MEM = 3'd3, FLAG = 3'd4;
    logic [2:0] state;
    logic md;
    logic [REG_AW-1:0] hi_addr;
    logic [DATA_W-1:0] hi_data;
    logic accept, done, is_md, is_store, is_cmp, is_nop;
    assign is_md    = opcode == OPC_MUL || opcode == OPC_DIV;
    assign is_store = opcode == OPC_STORE;
    assign is_cmp   = opcode == OPC_CMP;
    assign is_nop   = opcode == OPC_NOP;
    assign in_ready = reset & ~(state == WR_LO & md);
    assign accept   = in_valid & in_ready;
    assign done     = (state == WR_LO & ~md) | state == WR_HI | state == WR_MEM | state == FLAG;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            md <= 1'b0;
            hi_addr <= '0;
            hi_data <= '0;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            mem_we <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            flag_z <= 1'b0;
            retire_count <= '0;
        end else begin
            rf_we <= 1'b0;
            mem_we <= 1'b0;
            if (done)
                retire_count <= retire_count + 16'd1;
            if (state == WR_LO && md) begin
                state <= WR_HI;
                rf_we <= 1'b1;
                rf_waddr <= hi_addr;
                rf_wdata <= hi_data;
            end else if (accept) begin
                // high byte and wrapped rd+1 held so execute may move on
                md <= is_md;
                hi_addr <= rd + 1'b1;
                hi_data <= result[2*DATA_W-1:DATA_W];
                if (!is_store && !is_nop)
                    flag_z <= zero_flag;
                state <= is_nop ? IDLE : is_store ? WR_MEM : is_cmp ? FLAG : WR_LO;
                if (is_store) begin
                    mem_we <= 1'b1;
                    mem_waddr <= mem_addr;
                    mem_wdata <= result[DATA_W-1:0];
                end else if (!is_nop && !is_cmp) begin
                    rf_we <= 1'b1;
                    rf_waddr <= rd;
                    rf_wdata <= result[DATA_W-1:0];
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: random and directed stimulus against a transaction-level scoreboard of expected writes, flag and retire count.
module tb_writeback_stage;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, zero_flag = 1'b0;
    logic [3:0] opcode = 4'hF;
    logic [2:0] rd = '0;
    logic [4:0] mem_addr = '0;
    logic [15:0] result = '0;
    logic in_ready, rf_we, mem_we, flag_z;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata, mem_wdata;
    logic [4:0] mem_waddr;
    logic [15:0] retire_count;

    writeback_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .mem_addr(mem_addr), .result(result),
        .zero_flag(zero_flag), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flag_z(flag_z), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit m;
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t wq[$];
    int rq[$];
    int cyc = 0, checks = 0, errors = 0, ready_block_cyc = -1;
    logic exp_flag = 1'b0;
    logic [15:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_flag_z", flag_z, 0);
        check("rst_count", retire_count, 0);
        wq.delete();
        rq.delete();
        exp_flag = 1'b0;
        exp_cnt = '0;
        ready_block_cyc = -1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One cycle: check what the DUT shows now, then present the next input.
    task automatic step(input bit v, input logic [3:0] op, input logic [2:0] r,
                        input logic [4:0] ma, input logic [15:0] res, input bit z);
        logic [2:0] r1;
        @(negedge clk);
        cyc++;
        while (rq.size() != 0 && rq[0] <= cyc) begin
            void'(rq.pop_front());
            exp_cnt++;
        end
        check("count", retire_count, exp_cnt);
        check("flag_z", flag_z, exp_flag);
        check("in_ready", in_ready, cyc != ready_block_cyc);
        check("we_exclusive", rf_we & mem_we, 0);
        if (wq.size() != 0 && wq[0].c == cyc) begin
            check("rf_we", rf_we, !wq[0].m);
            check("mem_we", mem_we, wq[0].m);
            if (wq[0].m) begin
                check("mem_waddr", mem_waddr, wq[0].a);
                check("mem_wdata", mem_wdata, wq[0].d);
            end else begin
                check("rf_waddr", rf_waddr, wq[0].a[2:0]);
                check("rf_wdata", rf_wdata, wq[0].d);
            end
            void'(wq.pop_front());
        end else begin
            check("rf_we_idle", rf_we, 0);
            check("mem_we_idle", mem_we, 0);
        end
        in_valid = v;
        opcode = op;
        rd = r;
        mem_addr = ma;
        result = res;
        zero_flag = z;
        if (v && in_ready) begin
            r1 = r + 3'd1;
            if (op == 4'b1001) begin
                wq.push_back('{cyc + 1, 1'b1, ma, res[7:0]});
                rq.push_back(cyc + 2);
            end else if (op == 4'b1010) begin
                exp_flag = z;
                rq.push_back(cyc + 2);
            end else if (op == 4'b0101 || op == 4'b0110) begin
                exp_flag = z;
                wq.push_back('{cyc + 1, 1'b0, {2'b0, r}, res[7:0]});
                wq.push_back('{cyc + 2, 1'b0, {2'b0, r1}, res[15:8]});
                ready_block_cyc = cyc + 1;
                rq.push_back(cyc + 3);
            end else if (op != 4'b1111) begin
                exp_flag = z;
                wq.push_back('{cyc + 1, 1'b0, {2'b0, r}, res[7:0]});
                rq.push_back(cyc + 2);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'hF, 3'd0, 5'd0, 16'h0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        idle(2);
        step(1'b1, 4'b0000, 3'd3, 5'd0, 16'h00A5, 1'b0);
        idle(3);
        check("add_count", retire_count, 1);
        // reset while the MUL low byte is being written
        step(1'b1, 4'b0101, 3'd7, 5'd0, 16'h1234, 1'b0);
        step(1'b0, 4'hF, 3'd0, 5'd0, 16'h0, 1'b0);
        do_reset();
        idle(4);
        check("mid_mul_reset_count", retire_count, 0);
        step(1'b1, 4'b0101, 3'd7, 5'd0, 16'h1234, 1'b1);
        idle(4);
        check("mul_count", retire_count, 1);
        step(1'b1, 4'b1010, 3'd0, 5'd0, 16'h0, 1'b1);
        step(1'b1, 4'b1001, 3'd0, 5'd31, 16'h00FF, 1'b0);
        idle(3);
        check("store_flag_hold", flag_z, 1);
        do_reset();
        step(1'b1, 4'b0000, 3'd1, 5'd0, 16'h0011, 1'b0);
        step(1'b1, 4'b1010, 3'd0, 5'd0, 16'h0, 1'b1);
        step(1'b1, 4'b1111, 3'd0, 5'd0, 16'h0, 1'b0);
        step(1'b1, 4'b0011, 3'd2, 5'd0, 16'h0022, 1'b1);
        idle(3);
        check("b2b_count", retire_count, 3);
        check("b2b_flag", flag_z, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), 16'($urandom), 1'($urandom_range(0, 1)));
        idle(4);
        do_reset();
        for (int i = 0; i < 65535; i++) step(1'b1, 4'b1010, 3'd0, 5'd0, 16'h0, 1'(i & 1));
        idle(3);
        check("count_ffff", retire_count, 16'hFFFF);
        step(1'b1, 4'b0001, 3'd4, 5'd0, 16'h0077, 1'b0);
        idle(3);
        check("count_wrap", retire_count, 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
